// File: rtl/gravity_timer.sv
// Gravity engine: derives the per-level fall period by iterated fixed-point scaling, then paces fall ticks.
// Optional soft-drop acceleration is enabled with `define GRAVITY_SOFT_DROP_EN.
module gravity_timer #(
    parameter int BASE_PERIOD     = 148500000,
    parameter int RATIO_NUM       = 203,
    parameter int RATIO_SHIFT     = 8,
    parameter int MIN_PERIOD      = 122350,
    parameter int MAX_LEVEL       = 19,
    parameter int LEVEL_WIDTH     = 5,
    parameter int COUNT_WIDTH     = 28,
    parameter int SOFT_DROP_SHIFT = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [LEVEL_WIDTH-1:0] level_in,
    input  logic                   enable_in,
    input  logic                   restart_in,
`ifdef GRAVITY_SOFT_DROP_EN
    input  logic                   soft_drop_in,
`endif
    output logic                   fall_tick_out,
    output logic [COUNT_WIDTH-1:0] period_out,
    output logic                   period_valid_out,
    output logic                   busy_out
);
    localparam int PW = COUNT_WIDTH + RATIO_SHIFT + 1;
    localparam logic [COUNT_WIDTH-1:0] BASE_P = COUNT_WIDTH'(BASE_PERIOD);
    localparam logic [PW-1:0]          MIN_P  = PW'(MIN_PERIOD);
    localparam logic [PW-1:0]          RATIO  = PW'(RATIO_NUM);
    localparam logic [LEVEL_WIDTH-1:0] MAX_L  = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [LEVEL_WIDTH-1:0] ONE_L  = LEVEL_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] ONE_C  = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_RUN} state_t;

    state_t                 state;
    logic [LEVEL_WIDTH-1:0] lvl_eff, lvl_q, steps;
    logic [COUNT_WIDTH-1:0] acc, acc_next, counter, thresh;
    logic [PW-1:0]          prod, scaled;

    always_comb begin
        if (level_in == '0)
            lvl_eff = ONE_L;
        else if (level_in > MAX_L)
            lvl_eff = MAX_L;
        else
            lvl_eff = level_in;
    end

    // Full-width product so no bits are lost before the fixed-point shift.
    assign prod     = PW'(acc) * RATIO;
    assign scaled   = prod >> RATIO_SHIFT;
    assign acc_next = (scaled < MIN_P) ? COUNT_WIDTH'(MIN_P) : COUNT_WIDTH'(scaled);

    always_comb begin
        thresh = period_out;
`ifdef GRAVITY_SOFT_DROP_EN
        if (soft_drop_in) begin
            thresh = period_out >> SOFT_DROP_SHIFT;
            if (thresh == '0)
                thresh = ONE_C;
        end
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= S_LOAD;
            lvl_q            <= ONE_L;
            acc              <= BASE_P;
            steps            <= '0;
            period_out       <= BASE_P;
            counter          <= '0;
            fall_tick_out    <= 1'b0;
            period_valid_out <= 1'b0;
            busy_out         <= 1'b1;
        end else begin
            fall_tick_out <= 1'b0;
            case (state)
                S_LOAD: begin
                    lvl_q <= lvl_eff;
                    acc   <= BASE_P;
                    steps <= lvl_eff - ONE_L;
                    if (lvl_eff == ONE_L) begin
                        state            <= S_RUN;
                        period_out       <= BASE_P;
                        period_valid_out <= 1'b1;
                        busy_out         <= 1'b0;
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc   <= acc_next;
                    steps <= steps - ONE_L;
                    if (steps == ONE_L) begin
                        state            <= S_RUN;
                        period_out       <= acc_next;
                        period_valid_out <= 1'b1;
                        busy_out         <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (lvl_eff != lvl_q) begin
                        state            <= S_LOAD;
                        period_valid_out <= 1'b0;
                        busy_out         <= 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase

            // >= rather than == so a shrunken threshold fires at once instead of wrapping.
            if (restart_in)
                counter <= '0;
            else if (state == S_RUN && enable_in) begin
                if (counter >= thresh - ONE_C) begin
                    fall_tick_out <= 1'b1;
                    counter       <= '0;
                end else begin
                    counter <= counter + ONE_C;
                end
            end
        end
    end

endmodule

// File: tb/tb_gravity_timer.sv
// Directed bench for gravity_timer with small parameters (BASE 100, ratio 1/2, floor 10).
// Soft-drop steps are only compiled when GRAVITY_SOFT_DROP_EN is defined.
module tb_gravity_timer;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [4:0]  level_in;
    logic        enable_in;
    logic        restart_in;
    logic        soft_drop_in;
    logic        fall_tick_out;
    logic [27:0] period_out;
    logic        period_valid_out;
    logic        busy_out;

    int total = 0;
    int bad   = 0;
    int n;

    gravity_timer #(
        .BASE_PERIOD(100), .RATIO_NUM(128), .RATIO_SHIFT(8), .MIN_PERIOD(10),
        .MAX_LEVEL(19), .LEVEL_WIDTH(5), .COUNT_WIDTH(28), .SOFT_DROP_SHIFT(2)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .level_in(level_in),
        .enable_in(enable_in),
        .restart_in(restart_in),
`ifdef GRAVITY_SOFT_DROP_EN
        .soft_drop_in(soft_drop_in),
`endif
        .fall_tick_out(fall_tick_out),
        .period_out(period_out),
        .period_valid_out(period_valid_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_tick(input int limit, output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (!fall_tick_out && cnt < limit);
    endtask

    task automatic wait_valid(input int limit, output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (!period_valid_out && cnt < limit);
    endtask

    initial begin
        rst_in = 1'b1; level_in = 5'd1; enable_in = 1'b1; restart_in = 1'b0; soft_drop_in = 1'b0;
        step(3);
        chk("rst_busy", busy_out, 1);
        chk("rst_valid", period_valid_out, 0);
        chk("rst_tick", fall_tick_out, 0);
        chk("rst_period", period_out, 100);

        // Level 1 out of reset: LOAD goes straight to RUN.
        rst_in = 1'b0;
        step(2);
        chk("l1_busy", busy_out, 0);
        chk("l1_valid", period_valid_out, 1);
        chk("l1_period", period_out, 100);
        wait_tick(150, n);
        chk("l1_first_tick", n, 99);
        wait_tick(150, n);
        chk("l1_spacing", n, 100);
        step(1);
        chk("tick_one_cycle", fall_tick_out, 0);
        wait_tick(150, n);
        chk("l1_spacing2", n, 99);

        // Level 3: 100 -> 50 -> 25, valid 4 cycles after the change.
        level_in = 5'd3;
        step(1);
        chk("l3_valid_drop", period_valid_out, 0);
        chk("l3_busy_rise", busy_out, 1);
        wait_valid(40, n);
        chk("l3_latency", n + 1, 4);
        chk("l3_period", period_out, 25);
        chk("l3_busy_fall", busy_out, 0);
        restart_in = 1'b1;
        step(1);
        chk("l3_restart_notick", fall_tick_out, 0);
        restart_in = 1'b0;
        wait_tick(60, n);
        chk("l3_first_tick", n, 25);
        wait_tick(60, n);
        chk("l3_spacing", n, 25);

        // Level 5 hits the floor; 31 clamps to 19; 0 acts as 1.
        level_in = 5'd5;
        wait_valid(40, n);
        chk("l5_latency", n, 6);
        chk("l5_period", period_out, 10);
        level_in = 5'd31;
        wait_valid(40, n);
        chk("l31_latency", n, 20);
        chk("l31_period", period_out, 10);
        level_in = 5'd0;
        wait_valid(40, n);
        chk("l0_latency", n, 2);
        chk("l0_period", period_out, 100);

        restart_in = 1'b1;
        step(1);
        restart_in = 1'b0;
        wait_tick(150, n);
        chk("l0_tick", n, 100);

        // Restart coinciding with the tick condition suppresses it.
        step(99);
        restart_in = 1'b1;
        step(1);
        chk("restart_at_99", fall_tick_out, 0);
        restart_in = 1'b0;
        wait_tick(150, n);
        chk("restart_next_tick", n, 100);

        // 37-cycle pause mid-count delays the tick by 37.
        restart_in = 1'b1;
        step(1);
        restart_in = 1'b0;
        step(20);
        enable_in = 1'b0;
        step(37);
        chk("pause_notick", fall_tick_out, 0);
        enable_in = 1'b1;
        wait_tick(200, n);
        chk("pause_delay", 20 + 37 + n, 137);

`ifdef GRAVITY_SOFT_DROP_EN
        step(60);
        soft_drop_in = 1'b1;
        step(1);
        chk("soft_immediate", fall_tick_out, 1);
        wait_tick(60, n);
        chk("soft_spacing", n, 25);
        soft_drop_in = 1'b0;
        wait_tick(150, n);
        chk("soft_release", n, 100);
`endif

        // Reset in the middle of the level-10 computation.
        level_in = 5'd2;
        wait_valid(40, n);
        chk("l2_latency", n, 3);
        chk("l2_period", period_out, 50);
        level_in = 5'd10;
        step(3);
        chk("l10_busy_calc", busy_out, 1);
        #1 rst_in = 1'b1;
        #1;
        chk("async_period", period_out, 100);
        chk("async_busy", busy_out, 1);
        chk("async_valid", period_valid_out, 0);
        chk("async_tick", fall_tick_out, 0);
        #1 rst_in = 1'b0;
        wait_valid(40, n);
        chk("l10_latency", n, 10);
        chk("l10_period", period_out, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
